// File: rtl/spi_byte_interface.sv
// SPI mode-0 slave front end: synchronises sclk/cs_n/mosi into the clk domain,
// deserialises MSB-first bytes and serialises a handshaked response byte on miso.
module spi_byte_interface #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TX_IDLE     = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       spi_rx_valid,
    output logic [7:0] spi_rx_byte,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_taken,
    output logic       frame_active
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic       r_miso;
    logic       r_rx_done;
    logic       r_rx_valid;
    logic [7:0] r_rx_byte;
    logic       r_tx_taken;

    logic       w_sclk_s;
    logic       w_cs_s;
    logic       w_mosi_s;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_frame_start;
    logic       w_byte_done;
    logic       w_load;
    logic [7:0] w_load_byte;
    logic [2:0] w_tx_idx;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    assign w_cs_fall     = r_cs_prev & ~w_cs_s;
    assign w_cs_rise     = ~r_cs_prev & w_cs_s;
    assign w_sclk_rise   = w_sclk_s & ~r_sclk_prev & ~w_cs_s & (r_state == ST_ACTIVE);
    assign w_sclk_fall   = ~w_sclk_s & r_sclk_prev & ~w_cs_s & (r_state == ST_ACTIVE);
    assign w_frame_start = w_cs_fall & (r_state == ST_IDLE);
    assign w_byte_done   = w_sclk_rise & (r_bit_cnt == 3'd7);
    assign w_load        = w_frame_start | w_byte_done;
    assign w_load_byte   = tx_valid ? tx_byte : TX_IDLE;
    assign w_tx_idx      = 3'd7 - r_bit_cnt;

    assign miso         = r_miso;
    assign miso_oe      = (r_state == ST_ACTIVE);
    assign frame_active = (r_state == ST_ACTIVE);
    assign spi_rx_valid = r_rx_valid;
    assign spi_rx_byte  = r_rx_byte;
    assign tx_taken     = r_tx_taken;

    // Pin synchronisers plus the previous-value stage used for edge detection.
    // The cs_n chain resets to "selected" so a frame already running at reset
    // release never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{1'b0}};
            r_cs_sync   <= {SYNC_STAGES{1'b0}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame next-state: only a detected cs_n falling edge opens a frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit counter, shifters, miso and the rx/tx strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'h00;
            r_miso     <= 1'b0;
            r_rx_done  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_byte  <= 8'h00;
            r_tx_taken <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_bit_cnt <= 3'd0;
                r_miso    <= w_load_byte[7];
            end else if (w_cs_rise) begin
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
            end else if (w_sclk_rise) begin
                r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end else if (w_sclk_fall) begin
                // after the bit-7 rising edge the count is 0, selecting the new MSB
                r_miso <= r_tx_shift[w_tx_idx];
            end
            if (w_load) begin
                r_tx_shift <= w_load_byte;
            end
            r_tx_taken <= w_load & tx_valid;
            r_rx_done  <= w_byte_done;
            r_rx_valid <= r_rx_done;
            if (r_rx_done) begin
                r_rx_byte <= r_rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_interface.sv
// Self-checking bench for spi_byte_interface: a host-level SPI model predicts
// strobes, received bytes, miso bits and frame state cycle by cycle.
module tb_spi_byte_interface;

    localparam int         SYNC = 2;
    localparam logic [7:0] IDLE = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi, tx_valid;
    logic [7:0] tx_byte;
    logic       miso, miso_oe, spi_rx_valid, tx_taken, frame_active;
    logic [7:0] spi_rx_byte;

    spi_byte_interface #(.SYNC_STAGES(SYNC), .TX_IDLE(IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .spi_rx_valid(spi_rx_valid),
        .spi_rx_byte(spi_rx_byte), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .tx_taken(tx_taken), .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] b;
    } ev_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    ev_t        rx_q[$];
    ev_t        frame_q[$];
    int         taken_q[$];
    logic [7:0] rd_log[$];

    logic [7:0] m_byte    = 8'h00;
    logic       m_frame   = 1'b0;
    int         valid_seen = 0;
    int         taken_seen = 0;
    int         last_valid_cyc = 0;
    int         last_8th_cyc   = 0;

    logic       m_armed = 1'b0;
    int         host_bits = 0;
    logic [7:0] rx_acc = 8'h00;
    logic [7:0] rd_acc = 8'h00;
    logic [7:0] cur_tx = 8'h00;
    logic       offer_valid = 1'b0;
    logic [7:0] offer_byte  = 8'h00;
    int         drop_at = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", 32'(spi_rx_valid), 32'd0);
            chk("rst_byte", 32'(spi_rx_byte), 32'd0);
            chk("rst_taken", 32'(tx_taken), 32'd0);
            chk("rst_frame", 32'(frame_active), 32'd0);
            chk("rst_oe", 32'(miso_oe), 32'd0);
            chk("rst_miso", 32'(miso), 32'd0);
        end else begin
            logic exp_v, exp_t;
            while (frame_q.size() > 0 && frame_q[0].c <= cyc) begin
                m_frame = frame_q[0].b[0];
                void'(frame_q.pop_front());
            end
            exp_v = 1'b0;
            if (rx_q.size() > 0 && rx_q[0].c == cyc) begin
                exp_v  = 1'b1;
                m_byte = rx_q[0].b;
                void'(rx_q.pop_front());
            end
            exp_t = 1'b0;
            if (taken_q.size() > 0 && taken_q[0] == cyc) begin
                exp_t = 1'b1;
                void'(taken_q.pop_front());
            end
            chk("rx_valid", 32'(spi_rx_valid), 32'(exp_v));
            chk("rx_byte", 32'(spi_rx_byte), 32'(m_byte));
            chk("tx_taken", 32'(tx_taken), 32'(exp_t));
            chk("frame_active", 32'(frame_active), 32'(m_frame));
            chk("miso_oe", 32'(miso_oe), 32'(m_frame));
            if (spi_rx_valid === 1'b1) begin
                valid_seen++;
                last_valid_cyc = cyc;
            end
            if (tx_taken === 1'b1) taken_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (drop_at == cyc) begin
            tx_valid = 1'b0;
            drop_at  = -1;
        end
    endtask

    task automatic set_offer(input logic [7:0] b);
        offer_valid = 1'b1;
        offer_byte  = b;
        tx_valid    = 1'b1;
        tx_byte     = b;
    endtask

    task automatic do_load(input int k);
        if (offer_valid) begin
            cur_tx = offer_byte;
            taken_q.push_back(k + SYNC + 1);
            drop_at     = k + SYNC + 1;
            offer_valid = 1'b0;
        end else begin
            cur_tx = IDLE;
        end
    endtask

    task automatic cs_fall();
        ev_t e;
        cs_n      = 1'b0;
        m_armed   = 1'b1;
        host_bits = 0;
        e.c = cyc + SYNC + 1;
        e.b = 8'h01;
        frame_q.push_back(e);
        do_load(cyc);
        repeat (6) tick();
    endtask

    task automatic cs_rise();
        ev_t e;
        repeat (4) tick();
        cs_n      = 1'b1;
        m_armed   = 1'b0;
        host_bits = 0;
        e.c = cyc + SYNC + 1;
        e.b = 8'h00;
        frame_q.push_back(e);
        repeat (6) tick();
    endtask

    task automatic send_bit(input logic b);
        ev_t e;
        mosi = b;
        repeat (4) tick();
        sclk = 1'b1;
        if (m_armed) begin
            chk("miso_bit", 32'(miso), 32'(cur_tx[7 - host_bits]));
            rd_acc = {rd_acc[6:0], miso};
            rx_acc = {rx_acc[6:0], b};
            host_bits++;
            if (host_bits == 8) begin
                e.c = cyc + SYNC + 2;
                e.b = rx_acc;
                rx_q.push_back(e);
                rd_log.push_back(rd_acc);
                last_8th_cyc = cyc;
                do_load(cyc);
                host_bits = 0;
            end
        end
        repeat (4) tick();
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic offer_mid, input logic [7:0] ob);
        for (int i = 7; i >= 0; i--) begin
            if (i == 3 && offer_mid && !offer_valid && !tx_valid) set_offer(ob);
            send_bit(b[i]);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("async_rst_frame", 32'(frame_active), 32'd0);
        chk("async_rst_byte", 32'(spi_rx_byte), 32'd0);
        rx_q.delete();
        taken_q.delete();
        frame_q.delete();
        m_frame     = 1'b0;
        m_byte      = 8'h00;
        m_armed     = 1'b0;
        host_bits   = 0;
        drop_at     = -1;
        offer_valid = 1'b0;
        tx_valid    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    logic [7:0] wr_frame [8] = '{8'h01, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    initial begin
        int v0, t0;
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_valid = 1'b0; tx_byte = 8'h00;
        for (int i = 0; i < 6; i++) begin
            repeat (2) tick();
            sclk = ~sclk;
        end
        sclk  = 1'b0;
        rst_n = 1'b1;
        repeat (8) tick();
        chk("post_rst_valid_cnt", 32'(valid_seen), 32'd0);

        // single byte
        v0 = valid_seen;
        cs_fall();
        send_byte(8'hA5, 1'b0, 8'h00);
        cs_rise();
        chk("a5_count", 32'(valid_seen - v0), 32'd1);
        chk("a5_value", 32'(spi_rx_byte), 32'hA5);
        chk("a5_latency", 32'(last_valid_cyc - last_8th_cyc), 32'd4);

        // eight-byte write frame
        v0 = valid_seen;
        cs_fall();
        for (int i = 0; i < 8; i++) send_byte(wr_frame[i], 1'b0, 8'h00);
        cs_rise();
        chk("wr_count", 32'(valid_seen - v0), 32'd8);
        chk("wr_last", 32'(spi_rx_byte), 32'hEF);

        // abort after five bits
        v0 = valid_seen;
        cs_fall();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        cs_rise();
        cs_fall();
        send_byte(8'h3C, 1'b0, 8'h00);
        cs_rise();
        chk("abort_count", 32'(valid_seen - v0), 32'd1);
        chk("abort_value", 32'(spi_rx_byte), 32'h3C);

        // tx handshake
        rd_log.delete();
        t0 = taken_seen;
        set_offer(8'h96);
        repeat (3) tick();
        cs_fall();
        send_byte(8'h11, 1'b0, 8'h00);
        send_byte(8'h22, 1'b0, 8'h00);
        cs_rise();
        chk("tx_rd0", 32'(rd_log[0]), 32'h96);
        chk("tx_rd1", 32'(rd_log[1]), 32'h00);
        chk("tx_taken_cnt", 32'(taken_seen - t0), 32'd1);
        chk("tx_oe_off", 32'(miso_oe), 32'd0);

        // async reset mid-frame
        cs_fall();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        tick();
        v0 = valid_seen;
        pulse_reset();
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        send_byte(8'hC3, 1'b0, 8'h00);
        chk("rst_no_strobe", 32'(valid_seen - v0), 32'd0);
        cs_rise();
        cs_fall();
        send_byte(8'h5A, 1'b0, 8'h00);
        cs_rise();
        chk("rst_fresh_count", 32'(valid_seen - v0), 32'd1);
        chk("rst_fresh_value", 32'(spi_rx_byte), 32'h5A);

        // randomized frames with random tx offers
        for (int f = 0; f < 20; f++) begin
            int nb;
            nb = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1 && !offer_valid && !tx_valid) begin
                set_offer(8'($urandom_range(0, 255)));
                tick();
            end
            cs_fall();
            for (int b = 0; b < nb; b++) begin
                send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1),
                          8'($urandom_range(0, 255)));
            end
            cs_rise();
        end
        repeat (8) tick();
        chk("rx_q_drained", 32'(rx_q.size()), 32'd0);
        chk("taken_q_drained", 32'(taken_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
